ksa_engine: RTL and testbench

Runs the RC4 key-scheduling algorithm (KSA) over a 256×8 S-box memory for one 24-bit candidate key. It is the stage directly downstream of `key_generator`: it takes each candidate key, initialises S, then permutes S with the key. When it pulses `done`, the S-box is ready for the PRGA/decrypt stage that follows it.

---
 rtl/ksa_engine.sv | 140 ++++++++++++++
 tb/tb_ksa_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ksa_engine.sv
// ksa_engine
// RC4 key-scheduling over an external 256x8 S-box memory with a 1-cycle
// registered read port. On start, the engine latches a candidate key and fills
// S with the identity permutation. It then runs the 256-step swap loop, spending
// 6 clocks on each step. When S is ready, done pulses for one cycle.
//
// Ports
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high
//   start    : run request, sampled only in IDLE
//   key      : candidate key, byte 0 = key[23:16]
//   busy     : engine owns the S-memory port (run in progress, done cycle excluded)
//   done     : one-cycle pulse when S is fully permuted
//   s_addr   : S-memory address
//   s_wdata  : S-memory write data
//   s_wren   : S-memory write enable
//   s_rdata  : S-memory read data, valid one cycle after s_addr
module ksa_engine #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rdata
);

  localparam int KW = 8 * KEY_BYTES;

  typedef enum logic [3:0] {
    IDLE, FILL, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, DONE
  } state_t;

  state_t          state, nxt;
  logic [KW-1:0]   key_r;
  logic [7:0]      i, j, si, sj;
  logic [1:0]      kidx;   // i mod 3, stepped alongside i
  logic [7:0]      kbyte;

  // Key byte for the current i (byte 0 is the most significant byte).
  always_comb begin
    case (kidx)
      2'd1:    kbyte = key_r[KW-9  -: 8];
      2'd2:    kbyte = key_r[KW-17 -: 8];
      default: kbyte = key_r[KW-1  -: 8];
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = FILL;
      FILL:  if (i == 8'hFF) nxt = RD_I;
      RD_I:  nxt = LAT_I;
      LAT_I: nxt = RD_J;
      RD_J:  nxt = LAT_J;
      LAT_J: nxt = WR_I;
      WR_I:  nxt = WR_J;
      WR_J:  nxt = (i == 8'hFF) ? DONE : RD_I;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Index, key and swap-operand registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_r <= '0;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
      kidx  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          key_r <= key;
          i     <= '0;
          j     <= '0;
          kidx  <= '0;
        end
        // The last fill write leaves i ready for the swap loop at 0.
        FILL:  i <= (i == 8'hFF) ? 8'h00 : i + 8'd1;
        LAT_I: begin
          si <= s_rdata;
          j  <= j + s_rdata + kbyte;
        end
        LAT_J: sj <= s_rdata;
        WR_J: if (i != 8'hFF) begin
          i    <= i + 8'd1;
          kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state, so reset clears them without waiting for a clock.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    s_addr  = 8'h00;
    s_wdata = 8'h00;
    s_wren  = 1'b0;
    case (state)
      FILL: begin
        busy = 1'b1; s_addr = i; s_wdata = i; s_wren = 1'b1;
      end
      RD_I, LAT_I: begin
        busy = 1'b1; s_addr = i;
      end
      // j already holds the updated value here.
      RD_J, LAT_J: begin
        busy = 1'b1; s_addr = j;
      end
      WR_I: begin
        busy = 1'b1; s_addr = i; s_wdata = sj; s_wren = 1'b1;
      end
      // If i == j, both writes put the original value back, so no special case is needed.
      WR_J: begin
        busy = 1'b1; s_addr = j; s_wdata = si; s_wren = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa_engine.sv
// tb_ksa_engine
// Scoreboard bench for ksa_engine. The stimulus side pushes the expected memory
// writes and done cycles for each run. The monitor pops those entries and
// compares them with every write and every done pulse that the DUT produces.
// The S memory is modelled as a RAM with a 1-cycle registered read.
module tb_ksa_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] key;
  logic        busy, done, s_wren;
  logic [7:0]  s_addr, s_wdata, s_rdata;

  ksa_engine #(.KEY_BYTES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key),
    .busy(busy), .done(done), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wren(s_wren), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  // S memory, 1-cycle read latency
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (s_wren) mem[s_addr] <= s_wdata;
    s_rdata <= mem[s_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  logic [15:0] wq[$];    // expected writes {addr,data}
  int          dq[$];    // expected done cycles
  logic [15:0] wlog[$];  // observed writes of the current run
  logic [7:0]  exps[256];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    else passed++;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (s_wren) begin
        wlog.push_back({s_addr, s_wdata});
        if (wq.size() == 0) chk("unexpected_write", {s_addr, s_wdata}, -1);
        else chk("write", {s_addr, s_wdata}, wq.pop_front());
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", cyc, -1);
        else chk("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  // Behavioural RC4 KSA: queue the full write sequence and keep the final S
  task automatic push_model(input logic [23:0] k);
    logic [7:0] s[256];
    logic [7:0] kb[3];
    logic [7:0] jj, t;
    kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
    for (int n = 0; n < 256; n++) begin
      s[n] = n[7:0];
      wq.push_back({n[7:0], n[7:0]});
    end
    jj = 8'h00;
    for (int n = 0; n < 256; n++) begin
      jj = jj + s[n] + kb[n % 3];
      wq.push_back({n[7:0], s[jj]});
      wq.push_back({jj, s[n]});
      t = s[n]; s[n] = s[jj]; s[jj] = t;
    end
    for (int n = 0; n < 256; n++) exps[n] = s[n];
  endtask

  // Raise start during an IDLE cycle; that cycle becomes cycle 0 of the run.
  task automatic launch(input logic [23:0] k, input int nruns, output int t0);
    wlog.delete();
    for (int r = 0; r < nruns; r++) push_model(k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    t0    = cyc;
    for (int r = 0; r < nruns; r++) dq.push_back(t0 + r * 1794 + 1793);
  endtask

  // Step through the run(s) and check the busy window. Optionally re-pulse
  // start and change key mid-run.
  task automatic wait_run(input int t0, input int nruns, input bit poke);
    int bad = 0;
    int d, rel;
    do begin
      @(negedge clk);
      d   = cyc - t0;
      rel = d % 1794;
      if (d == 1 && nruns == 1) start = 1'b0;
      if (d == 1795 && nruns > 1) start = 1'b0;
      if (poke && d == 500) begin start = 1'b1; key = 24'hFFFFFF; end
      if (poke && d == 510) start = 1'b0;
      if (busy !== (rel >= 1 && rel <= 1792)) bad++;
    end while (d < 1794 * nruns);
    chk("busy_window", bad, 0);
    chk("done_drained", dq.size(), 0);
    chk("writes_drained", wq.size(), 0);
  endtask

  task automatic check_mem();
    for (int n = 0; n < 256; n++) chk($sformatf("sbox[%0d]", n), mem[n], exps[n]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int nw;
    reset = 1'b1; start = 1'b0; key = 24'h0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wren", s_wren, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_wdata", s_wdata, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Identity key: fill pattern and trivial early swaps
    launch(24'h000000, 1, t0);
    wait_run(t0, 1, 1'b0);
    chk("write_count", wlog.size(), 768);
    chk("fill_first", wlog[0], 16'h0000);
    chk("fill_last", wlog[255], 16'hFFFF);
    chk("swap0_wr_i", wlog[256], 16'h0000);
    chk("swap0_wr_j", wlog[257], 16'h0000);
    chk("swap2_wr_i", wlog[260], 16'h0203);
    chk("swap2_wr_j", wlog[261], 16'h0302);
    check_mem();

    // Byte order: byte 0 is key[23:16]
    launch(24'h030000, 1, t0);
    wait_run(t0, 1, 1'b0);
    chk("order_wr_i", wlog[256], 16'h0003);
    chk("order_wr_j", wlog[257], 16'h0300);
    check_mem();

    launch(24'hFFFFFF, 1, t0);
    wait_run(t0, 1, 1'b0);
    check_mem();

    // Start re-pulsed and key changed mid-run; result follows latched key
    launch(24'h000002, 1, t0);
    wait_run(t0, 1, 1'b1);
    check_mem();

    // Start held high: back-to-back runs, done every 1794 cycles
    launch(24'h000002, 2, t0);
    wait_run(t0, 2, 1'b0);
    check_mem();

    // Reset mid-fill
    launch(24'h123456, 1, t0);
    @(negedge clk);
    start = 1'b0;
    while (cyc - t0 < 100) @(negedge clk);
    #2;
    reset = 1'b1;
    wq.delete();
    dq.delete();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_wren", s_wren, 0);
    chk("midrst_addr", s_addr, 0);
    chk("midrst_wdata", s_wdata, 0);
    @(negedge clk);
    reset = 1'b0;
    nw = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_wren || busy) nw++;
    end
    chk("post_rst_idle", nw, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
